// File: rtl/ahb_if_ls_arbiter_pkg.sv
// Shared AHB-Lite encodings and the data-phase / address-phase owner type.
package ahb_if_ls_arbiter_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } own_e;

endpackage

// File: rtl/ahb_if_ls_arbiter_req_buf.sv
// One-entry capture buffer for a losing address phase (addr/ctrl + valid).
module ahb_req_buf #(
    parameter int W = 40
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_set,
    input  logic         i_clr,
    input  logic [W-1:0] i_data,
    output logic         o_vld,
    output logic [W-1:0] o_data
);

    logic         r_vld;
    logic [W-1:0] r_data;

    // Capture has priority; capture and clear never target the same entry in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_data <= '0;
        end else if (i_set) begin
            r_vld  <= 1'b1;
            r_data <= i_data;
        end else if (i_clr) begin
            r_vld  <= 1'b0;
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;

endmodule

// File: rtl/ahb_if_ls_arbiter.sv
// Two-master (fetch I, load/store D) to one-slave AHB-Lite arbiter.
// Zero added latency for a lone master; the loser of a collision is parked in
// a one-entry buffer. D wins ties unless fetch has lost STARVE_MAX times in a row.
module ahb_if_ls_arbiter
    import ahb_if_ls_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_haddr,
    input  logic [1:0]        i_htrans,
    input  logic [2:0]        i_hsize,
    input  logic [3:0]        i_hprot,
    output logic              i_hready,
    output logic [DATA_W-1:0] i_hrdata,
    output logic [1:0]        i_hresp,
    input  logic [ADDR_W-1:0] d_haddr,
    input  logic [1:0]        d_htrans,
    input  logic              d_hwrite,
    input  logic [2:0]        d_hsize,
    input  logic [3:0]        d_hprot,
    input  logic [DATA_W-1:0] d_hwdata,
    output logic              d_hready,
    output logic [DATA_W-1:0] d_hrdata,
    output logic [ADDR_W-1:0] s_haddr,
    output logic [1:0]        s_htrans,
    output logic              s_hwrite,
    output logic [2:0]        s_hsize,
    output logic [3:0]        s_hprot,
    output logic [2:0]        s_hburst,
    output logic [DATA_W-1:0] s_hwdata,
    input  logic [DATA_W-1:0] s_hrdata,
    input  logic              s_hready,
    input  logic [1:0]        s_hresp
);

    // Payload layout: {write, prot, size, addr}
    localparam int PW = ADDR_W + 8;

    own_e              r_dp_own, r_ap_lock;
    own_e              w_dp_own_nxt, w_ap_lock_nxt, w_sel;
    logic [3:0]        r_starve_cnt, w_starve_nxt;

    logic [PW-1:0]     w_live_i_pl, w_live_d_pl;
    logic [PW-1:0]     w_pend_i_q, w_pend_d_q;
    logic [PW-1:0]     w_src_i, w_src_d, w_sel_pl;
    logic              w_pend_i_vld, w_pend_d_vld;
    logic              w_live_i, w_live_d, w_req_i, w_req_d;
    logic              w_acc_i, w_acc_d, w_cap_i, w_cap_d;
    logic              w_i_hready, w_d_hready;

    assign w_live_i_pl = {1'b0, i_hprot, i_hsize, i_haddr};
    assign w_live_d_pl = {d_hwrite, d_hprot, d_hsize, d_haddr};

    // A live request only counts while the master has nothing parked.
    assign w_live_i = (i_htrans == HTRANS_NONSEQ) && !w_pend_i_vld;
    assign w_live_d = (d_htrans == HTRANS_NONSEQ) && !w_pend_d_vld;
    assign w_req_i  = w_pend_i_vld || w_live_i;
    assign w_req_d  = w_pend_d_vld || w_live_d;

    assign w_src_i  = w_pend_i_vld ? w_pend_i_q : w_live_i_pl;
    assign w_src_d  = w_pend_d_vld ? w_pend_d_q : w_live_d_pl;

    // Arbitration: held address phase first, then starvation relief, then D over I.
    always_comb begin
        w_sel = OWN_NONE;
        if (r_ap_lock != OWN_NONE)
            w_sel = r_ap_lock;
        else if ((r_starve_cnt == 4'(STARVE_MAX)) && w_req_i)
            w_sel = OWN_I;
        else if (w_req_d)
            w_sel = OWN_D;
        else if (w_req_i)
            w_sel = OWN_I;
    end

    assign w_acc_i = (w_sel == OWN_I) && s_hready;
    assign w_acc_d = (w_sel == OWN_D) && s_hready;

    // Ready reflects the owned data phase, otherwise whether the buffer is free.
    assign w_i_hready = (r_dp_own == OWN_I) ? s_hready : !w_pend_i_vld;
    assign w_d_hready = (r_dp_own == OWN_D) ? s_hready : !w_pend_d_vld;

    // Master believes it was accepted (hready=1) but lost: park the request.
    assign w_cap_i = w_live_i && w_i_hready && !w_acc_i;
    assign w_cap_d = w_live_d && w_d_hready && !w_acc_d;

    ahb_req_buf #(.W(PW)) u_pend_i (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_set  (w_cap_i),
        .i_clr  (w_acc_i),
        .i_data (w_live_i_pl),
        .o_vld  (w_pend_i_vld),
        .o_data (w_pend_i_q)
    );

    ahb_req_buf #(.W(PW)) u_pend_d (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_set  (w_cap_d),
        .i_clr  (w_acc_d),
        .i_data (w_live_d_pl),
        .o_vld  (w_pend_d_vld),
        .o_data (w_pend_d_q)
    );

    // Next data-phase owner, address lock and starvation count.
    always_comb begin
        w_dp_own_nxt  = r_dp_own;
        w_ap_lock_nxt = r_ap_lock;
        w_starve_nxt  = r_starve_cnt;
        if (s_hready) begin
            w_dp_own_nxt  = w_sel;
            w_ap_lock_nxt = OWN_NONE;
        end else if (w_sel != OWN_NONE) begin
            w_ap_lock_nxt = w_sel;
        end
        if (w_acc_i)
            w_starve_nxt = 4'd0;
        else if (w_acc_d && w_req_i && (r_starve_cnt != 4'(STARVE_MAX)))
            w_starve_nxt = r_starve_cnt + 4'd1;
    end

    // State registers; reset drops everything including parked requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dp_own     <= OWN_NONE;
            r_ap_lock    <= OWN_NONE;
            r_starve_cnt <= 4'd0;
        end else begin
            r_dp_own     <= w_dp_own_nxt;
            r_ap_lock    <= w_ap_lock_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    assign w_sel_pl = (w_sel == OWN_I) ? w_src_i :
                      (w_sel == OWN_D) ? w_src_d : '0;

    assign s_haddr  = w_sel_pl[ADDR_W-1:0];
    assign s_hsize  = w_sel_pl[ADDR_W +: 3];
    assign s_hprot  = w_sel_pl[ADDR_W+3 +: 4];
    assign s_hwrite = w_sel_pl[PW-1];
    assign s_htrans = (w_sel != OWN_NONE) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign s_hburst = HBURST_SINGLE;
    assign s_hwdata = (r_dp_own == OWN_D) ? d_hwdata : '0;

    assign i_hready = w_i_hready;
    assign d_hready = w_d_hready;
    assign i_hrdata = s_hrdata;
    assign d_hrdata = s_hrdata;
    assign i_hresp  = (r_dp_own == OWN_I) ? s_hresp : HRESP_OKAY;

endmodule

// File: tb/tb_ahb_if_ls_arbiter.sv
// Bench for ahb_if_ls_arbiter: directed vector table, starvation/reset
// sequences, then random traffic against a request-queue reference model.
module tb_ahb_if_ls_arbiter;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_haddr;  logic [1:0] i_htrans; logic [2:0] i_hsize; logic [3:0] i_hprot;
    logic        i_hready; logic [31:0] i_hrdata; logic [1:0] i_hresp;
    logic [31:0] d_haddr;  logic [1:0] d_htrans; logic d_hwrite; logic [2:0] d_hsize;
    logic [3:0]  d_hprot;  logic [31:0] d_hwdata;
    logic        d_hready; logic [31:0] d_hrdata;
    logic [31:0] s_haddr;  logic [1:0] s_htrans; logic s_hwrite; logic [2:0] s_hsize;
    logic [3:0]  s_hprot;  logic [2:0] s_hburst; logic [31:0] s_hwdata;
    logic [31:0] s_hrdata; logic s_hready; logic [1:0] s_hresp;

    int n_tests = 0;
    int n_fail  = 0;

    ahb_if_ls_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_haddr(i_haddr), .i_htrans(i_htrans), .i_hsize(i_hsize), .i_hprot(i_hprot),
        .i_hready(i_hready), .i_hrdata(i_hrdata), .i_hresp(i_hresp),
        .d_haddr(d_haddr), .d_htrans(d_htrans), .d_hwrite(d_hwrite), .d_hsize(d_hsize),
        .d_hprot(d_hprot), .d_hwdata(d_hwdata), .d_hready(d_hready), .d_hrdata(d_hrdata),
        .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
        .s_hprot(s_hprot), .s_hburst(s_hburst), .s_hwdata(s_hwdata),
        .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_htrans = 2'b00; i_haddr = '0; i_hsize = 3'd2; i_hprot = 4'hC;
        d_htrans = 2'b00; d_haddr = '0; d_hwrite = 1'b0; d_hsize = 3'd2;
        d_hprot = 4'h3; d_hwdata = '0; s_hready = 1'b1; s_hresp = 2'b00; s_hrdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0] it; logic [31:0] ia;
        logic [1:0] dt; logic [31:0] da; logic dw; logic [31:0] wd;
        logic shr; logic [1:0] srs;
        logic [1:0] e_tr; logic [31:0] e_ad; logic e_wr; logic [31:0] e_wd;
        logic e_ir; logic e_dr; logic [1:0] e_irs;
    } vec_t;

    vec_t vt[18];

    // ---------------- reference model ----------------
    // Each master has a queue of requests it believes were accepted but the
    // slave has not yet taken; the head of that queue stands in for the live bus.
    typedef struct { logic [31:0] addr; logic wr; logic [2:0] size; logic [3:0] prot; } mreq_t;
    mreq_t wq_i[$];
    mreq_t wq_d[$];
    int    m_own, m_lock, m_starve;   // 0 = nobody, 1 = fetch, 2 = load/store

    task automatic model_reset();
        wq_i.delete(); wq_d.delete();
        m_own = 0; m_lock = 0; m_starve = 0;
    endtask

    task automatic model_check(input int cyc);
        mreq_t li, ld, ci, cd, g;
        bit    lvi, lvd, ri, rd, eir, edr;
        int    w;
        li  = '{i_haddr, 1'b0, i_hsize, i_hprot};
        ld  = '{d_haddr, d_hwrite, d_hsize, d_hprot};
        lvi = (i_htrans == 2'b10) && (wq_i.size() == 0);
        lvd = (d_htrans == 2'b10) && (wq_d.size() == 0);
        ri  = lvi || (wq_i.size() != 0);
        rd  = lvd || (wq_d.size() != 0);
        ci  = (wq_i.size() != 0) ? wq_i[0] : li;
        cd  = (wq_d.size() != 0) ? wq_d[0] : ld;
        if (m_lock != 0)            w = m_lock;
        else if (m_starve == SM && ri) w = 1;
        else if (rd)                w = 2;
        else if (ri)                w = 1;
        else                        w = 0;
        g   = (w == 1) ? ci : (w == 2) ? cd : '{32'h0, 1'b0, 3'h0, 4'h0};
        eir = (m_own == 1) ? s_hready : (wq_i.size() == 0);
        edr = (m_own == 2) ? s_hready : (wq_d.size() == 0);

        chk($sformatf("rnd%0d s_htrans", cyc), 32'(s_htrans), (w != 0) ? 32'h2 : 32'h0);
        chk($sformatf("rnd%0d s_haddr", cyc), s_haddr, g.addr);
        chk($sformatf("rnd%0d s_hwrite", cyc), 32'(s_hwrite), 32'(g.wr));
        chk($sformatf("rnd%0d s_hsize", cyc), 32'(s_hsize), 32'(g.size));
        chk($sformatf("rnd%0d s_hprot", cyc), 32'(s_hprot), 32'(g.prot));
        chk($sformatf("rnd%0d s_hburst", cyc), 32'(s_hburst), 32'h0);
        chk($sformatf("rnd%0d s_hwdata", cyc), s_hwdata, (m_own == 2) ? d_hwdata : 32'h0);
        chk($sformatf("rnd%0d i_hready", cyc), 32'(i_hready), 32'(eir));
        chk($sformatf("rnd%0d d_hready", cyc), 32'(d_hready), 32'(edr));
        chk($sformatf("rnd%0d i_hresp", cyc), 32'(i_hresp), (m_own == 1) ? 32'(s_hresp) : 32'h0);
        chk($sformatf("rnd%0d rdata", cyc), i_hrdata ^ d_hrdata ^ s_hrdata, s_hrdata);

        // clock edge
        if (lvi && eir && !(s_hready && w == 1)) wq_i.push_back(li);
        if (lvd && edr && !(s_hready && w == 2)) wq_d.push_back(ld);
        if (s_hready) begin
            if (w == 1) begin
                if (wq_i.size() != 0 && !(lvi && eir)) void'(wq_i.pop_front());
                m_starve = 0;
            end else if (w == 2) begin
                if (wq_d.size() != 0 && !(lvd && edr)) void'(wq_d.pop_front());
                if (ri && m_starve < SM) m_starve++;
            end
            m_own  = w;
            m_lock = 0;
        end else if (w != 0) begin
            m_lock = w;
        end
    endtask

    initial begin
        // in, in-addr, d-trans, d-addr, d-write, d-wdata, s_hready, s_hresp | expected s_htrans, s_haddr, s_hwrite, s_hwdata, i_hready, d_hready, i_hresp
        vt[0]  = '{2, 32'h0,   0, 32'h0,         0, 32'h0,         1, 0,  2, 32'h0,         0, 32'h0,         1, 1, 0};
        vt[1]  = '{2, 32'h4,   0, 32'h0,         0, 32'h0,         1, 0,  2, 32'h4,         0, 32'h0,         1, 1, 0};
        vt[2]  = '{2, 32'h8,   0, 32'h0,         0, 32'h0,         1, 0,  2, 32'h8,         0, 32'h0,         1, 1, 0};
        vt[3]  = '{0, 32'h0,   0, 32'h0,         0, 32'h0,         1, 0,  0, 32'h0,         0, 32'h0,         1, 1, 0};
        vt[4]  = '{2, 32'h100, 2, 32'h2000_0000, 1, 32'h0,         1, 0,  2, 32'h2000_0000, 1, 32'h0,         1, 1, 0};
        vt[5]  = '{0, 32'h0,   0, 32'h0,         0, 32'hDEADBEEF,  1, 0,  2, 32'h100,       0, 32'hDEADBEEF,  0, 1, 0};
        vt[6]  = '{0, 32'h0,   0, 32'h0,         0, 32'h0,         1, 0,  0, 32'h0,         0, 32'h0,         1, 1, 0};
        vt[7]  = '{0, 32'h0,   2, 32'h3000,      0, 32'h0,         1, 0,  2, 32'h3000,      0, 32'h0,         1, 1, 0};
        vt[8]  = '{0, 32'h0,   2, 32'h3004,      1, 32'h0,         0, 0,  2, 32'h3004,      1, 32'h0,         1, 0, 0};
        vt[9]  = '{2, 32'h500, 2, 32'h3004,      1, 32'h0,         0, 0,  2, 32'h3004,      1, 32'h0,         1, 0, 0};
        vt[10] = '{0, 32'h0,   2, 32'h3004,      1, 32'h0,         0, 0,  2, 32'h3004,      1, 32'h0,         0, 0, 0};
        vt[11] = '{0, 32'h0,   2, 32'h3004,      1, 32'h0,         1, 0,  2, 32'h3004,      1, 32'h0,         0, 1, 0};
        vt[12] = '{0, 32'h0,   0, 32'h0,         0, 32'hCAFEF00D,  1, 0,  2, 32'h500,       0, 32'hCAFEF00D,  0, 1, 0};
        vt[13] = '{0, 32'h0,   0, 32'h0,         0, 32'h0,         1, 0,  0, 32'h0,         0, 32'h0,         1, 1, 0};
        vt[14] = '{2, 32'h600, 0, 32'h0,         0, 32'h0,         1, 0,  2, 32'h600,       0, 32'h0,         1, 1, 0};
        vt[15] = '{0, 32'h0,   2, 32'h4000,      0, 32'h0,         0, 1,  2, 32'h4000,      0, 32'h0,         0, 1, 1};
        vt[16] = '{0, 32'h0,   0, 32'h0,         0, 32'h0,         1, 1,  2, 32'h4000,      0, 32'h0,         1, 0, 1};
        vt[17] = '{0, 32'h0,   0, 32'h0,         0, 32'h0,         1, 0,  0, 32'h0,         0, 32'h0,         1, 1, 0};

        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("reset s_htrans", 32'(s_htrans), 32'h0);
        chk("reset i_hready", 32'(i_hready), 32'h1);
        chk("reset d_hready", 32'(d_hready), 32'h1);
        chk("reset i_hresp",  32'(i_hresp),  32'h0);
        chk("reset s_hwdata", s_hwdata,      32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // directed table
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            i_htrans = vt[k].it; i_haddr = vt[k].ia;
            d_htrans = vt[k].dt; d_haddr = vt[k].da; d_hwrite = vt[k].dw; d_hwdata = vt[k].wd;
            s_hready = vt[k].shr; s_hresp = vt[k].srs; s_hrdata = 32'h1000 + 32'(k);
            #1;
            chk($sformatf("vec%0d s_htrans", k), 32'(s_htrans), 32'(vt[k].e_tr));
            chk($sformatf("vec%0d s_haddr", k),  s_haddr,       vt[k].e_ad);
            chk($sformatf("vec%0d s_hwrite", k), 32'(s_hwrite), 32'(vt[k].e_wr));
            chk($sformatf("vec%0d s_hwdata", k), s_hwdata,      vt[k].e_wd);
            chk($sformatf("vec%0d i_hready", k), 32'(i_hready), 32'(vt[k].e_ir));
            chk($sformatf("vec%0d d_hready", k), 32'(d_hready), 32'(vt[k].e_dr));
            chk($sformatf("vec%0d i_hresp", k),  32'(i_hresp),  32'(vt[k].e_irs));
            chk($sformatf("vec%0d i_hrdata", k), i_hrdata,      32'h1000 + 32'(k));
            chk($sformatf("vec%0d d_hrdata", k), d_hrdata,      32'h1000 + 32'(k));
        end

        // starvation: D streams, fetch holds 0x40; fetch wins every fifth grant
        begin
            logic [31:0] exp_a[10];
            logic [31:0] da;
            exp_a = '{32'h8000, 32'h8004, 32'h8008, 32'h800C, 32'h40,
                      32'h8010, 32'h8014, 32'h8018, 32'h801C, 32'h40};
            do_reset();
            da = 32'h8000;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                i_htrans = 2'b10; i_haddr = 32'h40;
                d_htrans = 2'b10; d_haddr = da; d_hwrite = 1'b0; s_hready = 1'b1;
                #1;
                chk($sformatf("starve%0d s_haddr", c), s_haddr, exp_a[c]);
                if (d_hready) da = da + 32'h4;
            end
        end

        // asynchronous reset with both buffers occupied
        do_reset();
        @(negedge clk);
        i_htrans = 2'b10; i_haddr = 32'h700;
        d_htrans = 2'b10; d_haddr = 32'h9000; s_hready = 1'b0;
        #1;
        chk("rst-seq collide s_haddr", s_haddr, 32'h9000);
        @(negedge clk);
        idle_inputs(); s_hready = 1'b0;
        #1;
        chk("rst-seq i_hready parked", 32'(i_hready), 32'h0);
        chk("rst-seq d_hready parked", 32'(d_hready), 32'h0);
        chk("rst-seq locked s_haddr",  s_haddr,       32'h9000);
        #1 rst_n = 1'b0;
        #1;
        chk("rst-seq async s_htrans", 32'(s_htrans), 32'h0);
        chk("rst-seq async i_hready", 32'(i_hready), 32'h1);
        chk("rst-seq async d_hready", 32'(d_hready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1; s_hready = 1'b1;
        @(negedge clk);
        #1;
        chk("rst-seq cleared s_htrans", 32'(s_htrans), 32'h0);
        chk("rst-seq cleared i_hready", 32'(i_hready), 32'h1);

        // random traffic against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            i_htrans = ($urandom_range(1, 0) == 1) ? 2'b10 : 2'b00;
            i_haddr  = {$urandom_range(255, 0), 2'b00};
            i_hsize  = 3'($urandom_range(2, 0));
            i_hprot  = 4'($urandom_range(15, 0));
            d_htrans = ($urandom_range(2, 0) != 0) ? 2'b10 : 2'b00;
            d_haddr  = $urandom;
            d_hwrite = 1'($urandom_range(1, 0));
            d_hsize  = 3'($urandom_range(2, 0));
            d_hprot  = 4'($urandom_range(15, 0));
            d_hwdata = $urandom;
            s_hready = ($urandom_range(3, 0) != 0);
            s_hresp  = ($urandom_range(9, 0) == 0) ? 2'b01 : 2'b00;
            s_hrdata = $urandom;
            #1;
            model_check(c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
